note_scheduler: RTL and testbench
=================================

# note_scheduler

Round-robin arpeggiator that sits between the PS/2 key decoding and `speaker`. It holds up to NUM_SLOTS concurrently pressed notes and time-shares the single `speaker` voice among them. The held notes are cycled, each sounding for a fixed dwell, with a short silent gap between different notes. Its `note_div` output replaces the direct `note_decoder` → `speaker` connection; the upstream decoder supplies one press/release event per key change together with that key's divider.

## Interface
Parameters:
- NUM_SLOTS, 4, number of simultaneously held notes (power of two, ≥2)
- DWELL, 5_000_000, cycles each note sounds per turn (50 ms at 100 MHz)
- GAP, 250_000, silent cycles between two different notes
- DIV_W, 22, width of a note divider

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-low reset
- evt_valid  in  1  single-cycle event strobe
- evt_press  in  1  1 = key pressed, 0 = key released (qualified by evt_valid)
- evt_code  in  9  key scan code identifying the note
- evt_div  in  DIV_W  divider for evt_code (used on press only)
- note_div  out  DIV_W  divider to `speaker`; 0 = silence
- active_cnt  out  clog2(NUM_SLOTS)+1  number of occupied slots
- cur_slot  out  clog2(NUM_SLOTS)  slot currently selected
- drop  out  1  one-cycle pulse when a press is discarded because the table is full

## Operation
Slot table: NUM_SLOTS entries of {valid, code, div}.
- Press, code not held: write the entry into the lowest-index free slot.
- Press, code already held: no change; no drop.
- Press, table full: discard the event and pulse `drop`.
- Release, code held: clear that slot.
- Release, code not held: ignore.

State machine, with one counter `cnt`:
- IDLE: note_div = 0.
  - Table non-empty → PLAY; cur = lowest valid slot; cnt = 0.
- PLAY: note_div = div[cur]; cnt increments.
  - Slot cur invalid and table empty → IDLE.
  - Slot cur invalid and table non-empty → GAP, cnt = 0.
  - cnt = DWELL-1 and active_cnt = 1 → stay in PLAY, cnt = 0 (the single note sustains with no gap).
  - cnt = DWELL-1 and active_cnt > 1 → GAP, cnt = 0.
- GAP: note_div = 0; cnt increments.
  - Table empty → IDLE.
  - cnt = GAP-1 → PLAY; cur = first valid slot strictly after cur, searching circularly (which may wrap back to cur itself); cnt = 0.

Other rules:
- `cnt` width is clog2(max(DWELL, GAP)).
- Dividers are stored and forwarded unmodified; there is no arithmetic on them.

## Timing
Reset values: all slots invalid, state IDLE, cnt = 0, cur = 0, note_div = 0, active_cnt = 0, cur_slot = 0, drop = 0.

Pipeline:
- Event at cycle n → slot table and active_cnt updated at n+1 → state change at n+2 → note_div at n+2 (registered).
- `drop` asserts at n+1.

Boundary cases:
- A release of `cur` while in PLAY silences note_div within 2 cycles.
- A newly pressed note joins the rotation at the next GAP→PLAY search; it does not pre-empt the current note.
- Wrap-around: the search from slot NUM_SLOTS-1 continues at slot 0.
- In GAP, selection uses the table contents at the cycle cnt = GAP-1.
- Events are accepted in every state. evt_valid is at most one per cycle, so press and release never coincide.
- Reset asserted mid-operation clears everything immediately (asynchronous). On deassertion the block starts in IDLE.

## Structure
Shared package `keyboard_pkg` holds:
- state enum {IDLE, PLAY, GAP}
- SILENCE = 0 constant
- slot entry typedef {valid, code[8:0], div[DIV_W-1:0]}

Sub-module `slot_table` contains the storage, insert/release/duplicate/full logic, lowest-free priority encoder, circular next-valid search, and the active_cnt popcount. The FSM and counters live in `note_scheduler`.

## Test plan
Use a bench with DWELL = 8 and GAP = 2.
- Reset, then press code 0x1C with div 191571 → note_div = 191571 at +2 cycles and stays constant for more than 3×DWELL (sustain, no gaps).
- Press A (div 100), B (div 200), C (div 300) → note_div repeats the pattern 100×8, 0×2, 200×8, 0×2, 300×8, 0×2, then wraps back to 100.
- With 4 slots full, press a fifth code → `drop` high for exactly 1 cycle, active_cnt stays 4, rotation unchanged.
- While B is playing, release B → note_div = 0 within 2 cycles; after GAP the next note is C, and B never reappears.
- Press the same code twice, and release a code that was never pressed → active_cnt unchanged, no `drop`.
- Assert rst low mid-PLAY → note_div = 0 and active_cnt = 0 immediately; after release, output stays silent until a new press.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared types for the keyboard/speaker path: scheduler states, the silence
// divider and the slot-table entry layout.
package keyboard_pkg;

  localparam int NOTE_DIV_W = 22;
  localparam int CODE_W     = 9;

  localparam logic [NOTE_DIV_W-1:0] SILENCE = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_e;

  // div is sized for the widest divider the keyboard path carries
  typedef struct packed {
    logic                  valid;
    logic [CODE_W-1:0]     code;
    logic [NOTE_DIV_W-1:0] div;
  } slot_t;

endpackage

// File: rtl/note_scheduler_if.sv
// Press/release event channel from the key decoder into the note scheduler.
interface note_scheduler_if #(
  parameter int DIV_W = 22
);
  logic             evt_valid;
  logic             evt_press;
  logic [8:0]       evt_code;
  logic [DIV_W-1:0] evt_div;

  modport master (output evt_valid, output evt_press, output evt_code, output evt_div);
  modport slave  (input  evt_valid, input  evt_press, input  evt_code, input  evt_div);
endinterface

// File: rtl/note_scheduler_slot_table.sv
// Held-note table: insert/release bookkeeping, occupancy count and the
// lowest-valid / circular next-valid selectors used by the scheduler FSM.
module slot_table
  import keyboard_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  parameter  int DIV_W     = 22,
  localparam int IDX_W     = $clog2(NUM_SLOTS),
  localparam int ACT_W     = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  note_scheduler_if.slave      evt,
  input  logic [IDX_W-1:0]     cur,
  output logic [NUM_SLOTS-1:0] valid,
  output logic [DIV_W-1:0]     div [NUM_SLOTS],
  output logic [ACT_W-1:0]     active_cnt,
  output logic [IDX_W-1:0]     lowest_idx,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 drop
);

  slot_t            slot_q [NUM_SLOTS];
  slot_t            slot_d [NUM_SLOTS];
  logic             drop_q, drop_d;
  logic             hit, free_found;
  logic [IDX_W-1:0] hit_idx, free_idx, probe;

  // Descending scan so the lowest matching / free index wins
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_q[i].valid && (slot_q[i].code == evt.evt_code)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!slot_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    slot_d = slot_q;
    drop_d = 1'b0;
    if (evt.evt_valid) begin
      if (evt.evt_press) begin
        if (!hit) begin
          if (free_found) begin
            slot_d[free_idx].valid = 1'b1;
            slot_d[free_idx].code  = evt.evt_code;
            slot_d[free_idx].div   = NOTE_DIV_W'(evt.evt_div);
          end else begin
            drop_d = 1'b1;
          end
        end
      end else if (hit) begin
        slot_d[hit_idx].valid = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      valid[i] = slot_q[i].valid;
      div[i]   = DIV_W'(slot_q[i].div);
    end
  end

  // Offset NUM_SLOTS truncates to cur itself, so a lone note is re-selected
  always_comb begin
    active_cnt = '0;
    lowest_idx = '0;
    next_idx   = cur;
    probe      = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      active_cnt = active_cnt + ACT_W'(slot_q[i].valid);
      if (slot_q[i].valid) lowest_idx = IDX_W'(i);
    end
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      probe = cur + IDX_W'(k);
      if (slot_q[probe].valid) next_idx = probe;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
      drop_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      drop_q <= drop_d;
    end
  end

  assign drop = drop_q;

endmodule

// File: rtl/note_scheduler.sv
// Round-robin arpeggiator: time-shares one speaker voice among the held notes,
// each sounding for DWELL cycles with GAP silent cycles between different notes.
module note_scheduler
  import keyboard_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  parameter  int DWELL     = 5_000_000,
  parameter  int GAP       = 250_000,
  parameter  int DIV_W     = 22,
  localparam int IDX_W     = $clog2(NUM_SLOTS),
  localparam int ACT_W     = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  note_scheduler_if.slave   evt,
  output logic [DIV_W-1:0]  note_div,
  output logic [ACT_W-1:0]  active_cnt,
  output logic [IDX_W-1:0]  cur_slot,
  output logic              drop
);

  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [DIV_W-1:0] MUTE       = DIV_W'(SILENCE);

  logic [NUM_SLOTS-1:0] valid;
  logic [DIV_W-1:0]     div [NUM_SLOTS];
  logic [IDX_W-1:0]     lowest_idx, next_idx;
  logic                 empty, single;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0] note_div_q, note_div_d;

  slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .DIV_W     (DIV_W)
  ) u_slot_table (
    .clk        (clk),
    .rst        (rst),
    .evt        (evt),
    .cur        (cur_q),
    .valid      (valid),
    .div        (div),
    .active_cnt (active_cnt),
    .lowest_idx (lowest_idx),
    .next_idx   (next_idx),
    .drop       (drop)
  );

  assign empty  = (active_cnt == '0);
  assign single = (active_cnt == ACT_W'(1));

  // note_div is registered alongside the state, so it always matches state_q
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    note_div_d = MUTE;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          state_d    = ST_PLAY;
          cur_d      = lowest_idx;
          note_div_d = div[lowest_idx];
        end
      end
      ST_PLAY: begin
        cnt_d      = cnt_q + 1'b1;
        note_div_d = div[cur_q];
        if (!valid[cur_q]) begin
          note_div_d = MUTE;
          cnt_d      = '0;
          state_d    = empty ? ST_IDLE : ST_GAP;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (!single) begin
            state_d    = ST_GAP;
            note_div_d = MUTE;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (empty) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d    = ST_PLAY;
          cnt_d      = '0;
          cur_d      = next_idx;
          note_div_d = div[next_idx];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_q      <= '0;
      note_div_q <= MUTE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      note_div_q <= note_div_d;
    end
  end

  assign note_div = note_div_q;
  assign cur_slot = cur_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: a per-cycle behavioural model queues the
// expected outputs and a negedge monitor compares them against the DUT.
module tb_note_scheduler;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int GP    = 2;
  localparam int DIV_W = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  note_scheduler_if #(.DIV_W(DIV_W)) evt_if ();

  logic [DIV_W-1:0] note_div;
  logic [2:0]       active_cnt;
  logic [1:0]       cur_slot;
  logic             drop;

  note_scheduler #(
    .NUM_SLOTS (N),
    .DWELL     (DW),
    .GAP       (GP),
    .DIV_W     (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evt        (evt_if),
    .note_div   (note_div),
    .active_cnt (active_cnt),
    .cur_slot   (cur_slot),
    .drop       (drop)
  );

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [2:0]       act;
    logic [1:0]       cur;
    logic             drp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: held notes plus a countdown of cycles left in the phase
  bit               m_valid [N];
  logic [8:0]       m_code  [N];
  logic [DIV_W-1:0] m_div   [N];
  int               phase;     // 0 silent-idle, 1 sounding, 2 gap
  int               m_cur;
  int               m_left;
  logic [DIV_W-1:0] m_out;
  bit               m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int held_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic int first_valid_after(input int from);
    for (int k = 1; k <= N; k++) if (m_valid[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_code[i]  = '0;
      m_div[i]   = '0;
    end
    phase = 0; m_cur = 0; m_left = 0; m_out = '0; m_drop = 0;
  endtask

  task automatic model_step(input bit ev, input bit press, input logic [8:0] code,
                            input logic [DIV_W-1:0] dv);
    int a;
    int slot;
    a = held_count();
    case (phase)
      0: begin
        m_out = '0;
        if (a > 0) begin
          phase = 1; m_cur = first_valid_after(N - 1); m_left = DW; m_out = m_div[m_cur];
        end
      end
      1: begin
        m_left--;
        if (!m_valid[m_cur]) begin
          m_out = '0;
          if (a == 0) phase = 0;
          else begin phase = 2; m_left = GP; end
        end else if (m_left == 0) begin
          m_left = DW;
          if (a > 1) begin phase = 2; m_left = GP; m_out = '0; end
        end
      end
      default: begin
        if (a == 0) begin
          phase = 0; m_out = '0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_cur = first_valid_after(m_cur); phase = 1; m_left = DW; m_out = m_div[m_cur];
          end
        end
      end
    endcase
    m_drop = 0;
    if (ev) begin
      slot = -1;
      for (int i = 0; i < N; i++) if (m_valid[i] && m_code[i] == code) slot = i;
      if (press && slot < 0) begin
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        if (slot < 0) m_drop = 1;
        else begin m_valid[slot] = 1; m_code[slot] = code; m_div[slot] = dv; end
      end else if (!press && slot >= 0) begin
        m_valid[slot] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(evt_if.evt_valid, evt_if.evt_press, evt_if.evt_code, evt_if.evt_div);
    sb.push_back('{div: m_out, act: 3'(held_count()), cur: 2'(m_cur), drp: m_drop});
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("note_div",   32'(note_div),   32'(e.div));
      check("active_cnt", 32'(active_cnt), 32'(e.act));
      check("cur_slot",   32'(cur_slot),   32'(e.cur));
      check("drop",       32'(drop),       32'(e.drp));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit press, input logic [8:0] code, input logic [DIV_W-1:0] dv);
    @(negedge clk);
    evt_if.evt_valid = 1'b1;
    evt_if.evt_press = press;
    evt_if.evt_code  = code;
    evt_if.evt_div   = dv;
    @(negedge clk);
    evt_if.evt_valid = 1'b0;
  endtask

  // Waits (bounded) until the model says the given code is sounding
  task automatic wait_playing(input logic [8:0] code, input string name);
    int budget = 200;
    while (!(phase == 1 && m_code[m_cur] == code) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout waiting for code %0h to sound", name, code);
    end
  endtask

  logic [8:0] pool [6];

  initial begin
    pool = '{9'h1C, 9'h15, 9'h1D, 9'h24, 9'h2D, 9'h2C};
    evt_if.evt_valid = 1'b0;
    evt_if.evt_press = 1'b0;
    evt_if.evt_code  = '0;
    evt_if.evt_div   = '0;
    model_reset();
    rst = 1'b0;
    idle(3);
    check("reset note_div",   32'(note_div),   32'd0);
    check("reset active_cnt", 32'(active_cnt), 32'd0);
    check("reset cur_slot",   32'(cur_slot),   32'd0);
    check("reset drop",       32'(drop),       32'd0);
    rst = 1'b1;
    idle(2);

    // Single note sustains without gaps
    send(1, 9'h1C, 22'd191571);
    idle(3 * DW + 8);
    send(0, 9'h1C, '0);
    idle(6);

    // Three-note rotation with wrap back to the first
    send(1, 9'h15, 22'd100);
    send(1, 9'h1D, 22'd200);
    send(1, 9'h24, 22'd300);
    idle(4 * (DW + GP) + 6);

    // Table full: fifth press dropped
    send(1, 9'h2D, 22'd400);
    idle(3);
    send(1, 9'h2C, 22'd500);
    idle(2 * (DW + GP));
    send(0, 9'h2D, '0);
    idle(4);

    // Release the sounding note B
    wait_playing(9'h1D, "wait_B");
    idle(2);
    send(0, 9'h1D, '0);
    idle(3 * (DW + GP));

    // Duplicate press and release of an unknown code
    send(1, 9'h15, 22'd777);
    send(0, 9'h77, '0);
    idle(2 * (DW + GP));
    send(0, 9'h15, '0);
    send(0, 9'h24, '0);
    idle(5);

    // Randomised press/release traffic, including drops and wrap-around
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 2) != 0), pool[$urandom_range(0, 5)],
           DIV_W'($urandom_range(1, (1 << DIV_W) - 1)));
      idle($urandom_range(0, 12));
    end

    // Asynchronous reset while a note is sounding
    if (held_count() == 0) send(1, 9'h1C, 22'd191571);
    wait_playing(m_code[first_valid_after(N - 1)], "wait_play_for_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check("async rst note_div",   32'(note_div),   32'd0);
    check("async rst active_cnt", 32'(active_cnt), 32'd0);
    idle(3);
    rst = 1'b1;
    idle(10);
    send(1, 9'h24, 22'd300);
    idle(DW + 4);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
